bist_sequencer: RTL and testbench

Top-level controller for the memory BIST engines in the design. It is the initiator side of the engine interface: per-engine active-low reset, BistMode enable, and BistFail/BistFinish collection. It runs up to NUM_BIST engines either all in parallel or one at a time, and bounds each run with a watchdog. It reports per-engine fail and timeout vectors plus a single PASS flag to the test/debug register block.

---
 rtl/bist_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bist_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// Initiator-side controller for the memory BIST engines: runs all engines in one
// parallel group or one at a time, bounds each group with a watchdog, and collects results.
module bist_sequencer #(
  parameter int unsigned NUM_BIST    = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic                SEQ_MODE,
  output logic [NUM_BIST-1:0] BIST_RSTN,
  output logic [NUM_BIST-1:0] BIST_MODE,
  input  logic [NUM_BIST-1:0] BIST_FAIL,
  input  logic [NUM_BIST-1:0] BIST_FINISH,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [NUM_BIST-1:0] FAIL_VEC,
  output logic [NUM_BIST-1:0] TIMEOUT_VEC
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYC);
  localparam int unsigned   IW     = (NUM_BIST > 1) ? $clog2(NUM_BIST) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_BIST - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FIN} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                seq_q, seq_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NUM_BIST-1:0] fail_vec_q, fail_vec_d;
  logic [NUM_BIST-1:0] timeout_vec_q, timeout_vec_d;
  logic [NUM_BIST-1:0] bist_rstn_q, bist_rstn_d;
  logic [NUM_BIST-1:0] bist_mode_q, bist_mode_d;
  logic [NUM_BIST-1:0] grp;
  logic                finished;
  logic                expired;

  function automatic logic [NUM_BIST-1:0] grp_of(input logic seq, input logic [IW-1:0] idx);
    return seq ? (NUM_BIST'(1) << idx) : '1;
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    seq_d         = seq_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_vec_d    = fail_vec_q;
    timeout_vec_d = timeout_vec_q;
    bist_rstn_d   = bist_rstn_q;
    bist_mode_d   = bist_mode_q;
    grp           = grp_of(seq_q, idx_q);
    finished      = (BIST_FINISH & grp) == grp;
    expired       = timer_q == T_LAST;

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d       = S_ARM;
          seq_d         = SEQ_MODE;
          idx_d         = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_vec_d    = '0;
          timeout_vec_d = '0;
          bist_rstn_d   = grp_of(SEQ_MODE, '0);
          bist_mode_d   = '0;
        end
      end
      S_ARM: begin
        state_d     = S_RUN;
        timer_d     = '0;
        bist_rstn_d = grp;
        bist_mode_d = grp;
      end
      S_RUN: begin
        timer_d = timer_q + TW'(1);
        // Completion has priority over a watchdog expiring on the same edge.
        if (finished || expired) begin
          fail_vec_d  = fail_vec_q | (BIST_FAIL & grp);
          if (!finished) timeout_vec_d = timeout_vec_q | (grp & ~BIST_FINISH);
          bist_mode_d = '0;
          if (seq_q && (idx_q < I_LAST)) begin
            idx_d       = idx_q + IW'(1);
            bist_rstn_d = grp_of(1'b1, idx_q + IW'(1));
            state_d     = S_ARM;
          end else begin
            bist_rstn_d = '0;
            state_d     = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = ~|fail_vec_q & ~|timeout_vec_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      idx_d         = '0;
      timer_d       = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      fail_vec_d    = '0;
      timeout_vec_d = '0;
      bist_rstn_d   = '0;
      bist_mode_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      seq_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_vec_q    <= '0;
      timeout_vec_q <= '0;
      bist_rstn_q   <= '0;
      bist_mode_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      seq_q         <= seq_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_vec_q    <= fail_vec_d;
      timeout_vec_q <= timeout_vec_d;
      bist_rstn_q   <= bist_rstn_d;
      bist_mode_q   <= bist_mode_d;
    end
  end

  assign BIST_RSTN   = bist_rstn_q;
  assign BIST_MODE   = bist_mode_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PASS        = pass_q;
  assign FAIL_VEC    = fail_vec_q;
  assign TIMEOUT_VEC = timeout_vec_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: stub engines with programmable finish latency and a
// scoreboard of expected results consumed whenever DONE rises.
module tb_bist_sequencer;
  localparam int NB = 4;
  localparam int TO = 64;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, seq_mode = 1'b0;
  logic [NB-1:0] bist_rstn, bist_mode, bist_fail, bist_finish, fail_vec, timeout_vec;
  logic          busy, done, pass;
  logic          done_prev = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int lat[NB];
  bit fail_en[NB];
  int cnt[NB];
  int tr_val[$];
  int tr_len[$];

  typedef struct {
    logic [NB-1:0] f;
    logic [NB-1:0] t;
    logic          p;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bist_sequencer #(.NUM_BIST(NB), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .ABORT(abort), .SEQ_MODE(seq_mode),
    .BIST_RSTN(bist_rstn), .BIST_MODE(bist_mode), .BIST_FAIL(bist_fail),
    .BIST_FINISH(bist_finish), .BUSY(busy), .DONE(done), .PASS(pass),
    .FAIL_VEC(fail_vec), .TIMEOUT_VEC(timeout_vec)
  );

  // Stub engine: counts cycles in BistMode, FINISH once the count reaches lat.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (!bist_rstn[i]) cnt[i] <= 0;
      else if (bist_mode[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    bist_finish = '0;
    bist_fail   = '0;
    for (int i = 0; i < NB; i++) begin
      bist_finish[i] = bist_rstn[i] && (cnt[i] >= lat[i]);
      bist_fail[i]   = bist_rstn[i] && fail_en[i] && (cnt[i] >= lat[i] - 3);
    end
  end

  always @(negedge clk) begin
    if (done && !done_prev) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: DONE rose with no expected result queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({fail_vec, timeout_vec, pass} !== {e.f, e.t, e.p}) begin
          n_fail++;
          $display("FAIL sb_result: fail_vec=%b timeout_vec=%b pass=%b, expected %b %b %b",
                   fail_vec, timeout_vec, pass, e.f, e.t, e.p);
        end
      end
    end
    done_prev <= done;
  end

  task automatic set_stub(input int l0, input int l1, input int l2, input int l3, input bit [3:0] fe);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int i = 0; i < NB; i++) fail_en[i] = fe[i];
  endtask

  task automatic go(input logic seq);
    @(negedge clk); start = 1'b1; seq_mode = seq;
    @(negedge clk); start = 1'b0; seq_mode = 1'b0;
  endtask

  // Run-length trace of BIST_MODE, one sample per cycle, until DONE.
  task automatic collect(output bit ok);
    tr_val.delete(); tr_len.delete(); ok = 0;
    for (int c = 0; c < 5000; c++) begin
      if (done) begin ok = 1; break; end
      if (tr_val.size() > 0 && tr_val[tr_val.size()-1] == int'(bist_mode))
        tr_len[tr_len.size()-1] += 1;
      else begin
        tr_val.push_back(int'(bist_mode)); tr_len.push_back(1);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  function automatic string trace_str();
    string s = "";
    for (int i = 0; i < tr_val.size(); i++) s = {s, $sformatf("%0h*%0d ", tr_val[i], tr_len[i])};
    return s;
  endfunction

  task automatic test_reset;
    #12;
    n_checks++;
    if ({bist_rstn, bist_mode, busy, done, pass, fail_vec, timeout_vec} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rstn=%b mode=%b busy=%b done=%b pass=%b fv=%b tv=%b, expected all 0",
               bist_rstn, bist_mode, busy, done, pass, fail_vec, timeout_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parallel;
    bit ok;
    set_stub(20, 30, 40, 50, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0000, p: 1'b1});
    go(1'b0);
    n_checks++;
    if ({busy, bist_rstn, bist_mode} !== {1'b1, 4'hf, 4'h0}) begin
      n_fail++;
      $display("FAIL par_arm: busy=%b rstn=%b mode=%b, expected 1 1111 0000", busy, bist_rstn, bist_mode);
    end
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "0*1 f*51 0*1 ") begin
      n_fail++;
      $display("FAIL par_trace: got '%s' done=%0d, expected '0*1 f*51 0*1 '", trace_str(), ok);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, pass, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL par_done_hold: done=%b pass=%b busy=%b, expected 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_seq_fail;
    bit ok;
    set_stub(5, 6, 10, 7, 4'b0100);
    sb.push_back('{f: 4'b0100, t: 4'b0000, p: 1'b0});
    go(1'b1);
    n_checks++;
    if (bist_rstn !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_arm: rstn=%b busy=%b, expected 0001 1", bist_rstn, busy);
    end
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "0*1 1*6 0*1 2*7 0*1 4*11 0*1 8*8 0*1 ") begin
      n_fail++;
      $display("FAIL seq_trace: got '%s' done=%0d, expected '0*1 1*6 0*1 2*7 0*1 4*11 0*1 8*8 0*1 '",
               trace_str(), ok);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    set_stub(5, 100000, 5, 5, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0010, p: 1'b0});
    go(1'b1);
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "0*1 1*6 0*1 2*64 0*1 4*6 0*1 8*6 0*1 ") begin
      n_fail++;
      $display("FAIL to_trace: got '%s' done=%0d, expected '0*1 1*6 0*1 2*64 0*1 4*6 0*1 8*6 0*1 '",
               trace_str(), ok);
    end
  endtask

  task automatic test_timeout_boundary;
    bit ok;
    set_stub(63, 5, 5, 5, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0000, p: 1'b1});
    go(1'b1);
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "0*1 1*64 0*1 2*6 0*1 4*6 0*1 8*6 0*1 ") begin
      n_fail++;
      $display("FAIL tb63_trace: got '%s' done=%0d, expected '0*1 1*64 0*1 2*6 0*1 4*6 0*1 8*6 0*1 '",
               trace_str(), ok);
    end
    set_stub(64, 5, 5, 5, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0001, p: 1'b0});
    go(1'b1);
    collect(ok);
    n_checks++;
    if (!ok || sb.size() != 0) begin
      n_fail++;
      $display("FAIL tb64_done: done=%0d pending=%0d, expected 1 0", ok, sb.size());
    end
  endtask

  task automatic test_start_while_busy;
    bit ok;
    set_stub(20, 30, 40, 50, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0000, p: 1'b1});
    go(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 2); seq_mode = (i == 2);
    end
    start = 1'b0; seq_mode = 1'b0;
    n_checks++;
    if ({busy, bist_mode} !== {1'b1, 4'hf}) begin
      n_fail++;
      $display("FAIL busy_start_mode: busy=%b mode=%b, expected 1 1111", busy, bist_mode);
    end
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "f*42 0*1 ") begin
      n_fail++;
      $display("FAIL busy_start_trace: got '%s' done=%0d, expected 'f*42 0*1 '", trace_str(), ok);
    end
  endtask

  task automatic test_abort;
    bit ok;
    set_stub(100000, 100000, 100000, 100000, 4'b0000);
    go(1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_checks++;
    if ({busy, done, bist_rstn, bist_mode, fail_vec, timeout_vec} !== '0) begin
      n_fail++;
      $display("FAIL abort_run: busy=%b done=%b rstn=%b mode=%b fv=%b tv=%b, expected all 0",
               busy, done, bist_rstn, bist_mode, fail_vec, timeout_vec);
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, bist_rstn, bist_mode} !== '0) begin
      n_fail++;
      $display("FAIL abort_start_idle: busy=%b rstn=%b mode=%b, expected 0 0000 0000", busy, bist_rstn, bist_mode);
    end
    set_stub(5, 5, 5, 5, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0000, p: 1'b1});
    go(1'b0);
    collect(ok);
    n_checks++;
    if (!ok || trace_str() != "0*1 f*6 0*1 ") begin
      n_fail++;
      $display("FAIL abort_rerun: got '%s' done=%0d, expected '0*1 f*6 0*1 '", trace_str(), ok);
    end
  endtask

  task automatic test_rst_mid_run;
    bit ok;
    set_stub(100000, 100000, 100000, 100000, 4'b0000);
    go(1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bist_rstn, bist_mode, busy, done, pass, fail_vec, timeout_vec} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: rstn=%b mode=%b busy=%b done=%b, expected all 0", bist_rstn, bist_mode, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, bist_rstn, bist_mode} !== '0) begin
      n_fail++;
      $display("FAIL rst_idle: busy=%b rstn=%b mode=%b, expected 0 0000 0000", busy, bist_rstn, bist_mode);
    end
    set_stub(3, 3, 3, 3, 4'b0000);
    sb.push_back('{f: 4'b0000, t: 4'b0000, p: 1'b1});
    go(1'b1);
    collect(ok);
    n_checks++;
    if (!ok || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_rerun: done=%0d pending=%0d, expected 1 0", ok, sb.size());
    end
  endtask

  initial begin
    set_stub(100000, 100000, 100000, 100000, 4'b0000);
    test_reset();
    test_parallel();
    test_seq_fail();
    test_timeout();
    test_timeout_boundary();
    test_start_while_busy();
    test_abort();
    test_rst_mid_run();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d results pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
